// File: rtl/totd_trigger_gen.sv
// totd_trigger_gen: strobe-paced ToTd trigger with two-sided amplitude window, sliding occupancy and multiplicity.
// Define TOTD_GEN_HOLDOFF_EN to add a HOLDOFF-strobe retrigger holdoff after each TRIG.
module totd_trigger_gen #(
    parameter int NCH       = 3,
    parameter int ADC_BITS  = 12,
    parameter int INT_BITS  = 19,
    parameter int MAX_WIDTH = 120,
    parameter int WL_BITS   = 7
) (
    input  logic                                    CLK120,
    input  logic                                    RESET,
    input  logic                                    STROBE,
    input  logic                                    CLEAR,
    input  logic [NCH*ADC_BITS-1:0]                 ADC,
    input  logic [NCH*INT_BITS-1:0]                 INTG,
    input  logic [NCH*ADC_BITS-1:0]                 THRES,
    input  logic [NCH*ADC_BITS-1:0]                 UP,
    input  logic [NCH-1:0]                          TRIG_ENABLE,
    input  logic [$clog2(NCH+1)-1:0]                MULTIPLICITY,
    input  logic [WL_BITS-1:0]                      WIN_LEN,
    input  logic [WL_BITS-1:0]                      OCCUPANCY,
    input  logic [INT_BITS-1:0]                     INT_MIN,
    input  logic [15:0]                             HOLDOFF,
    output logic                                    TRIG,
    output logic [NCH-1:0]                          SB_TRIG,
    output logic [NCH*$clog2(MAX_WIDTH+1)-1:0]      OCC
);
    localparam int MW = $clog2(NCH+1);
    localparam int OW = $clog2(MAX_WIDTH+1);

    logic [NCH*ADC_BITS-1:0] r_adc, r_thres, r_up;
    logic [NCH*INT_BITS-1:0] r_intg1, r_intg2, r_intg3;
    logic [NCH-1:0]          r_en, r_hit, w_hit, w_sb;
    logic [WL_BITS-1:0]      r_wl, w_wl, w_tap;
    logic [MW-1:0]           w_cnt;
    logic                    r_trig_now, w_cond, w_fire, w_clr;

    assign w_wl  = (WIN_LEN == '0) ? WL_BITS'(1) :
                   (32'(WIN_LEN) > MAX_WIDTH) ? WL_BITS'(MAX_WIDTH) : WIN_LEN;
    assign w_tap = w_wl - WL_BITS'(1);
    // A window-length change realigns every count to the new tap by clearing.
    assign w_clr = CLEAR || (w_wl != r_wl);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [MAX_WIDTH-1:0] r_win;
        logic [OW-1:0]        r_occ;
        logic                 w_old;
        assign w_hit[c] = (r_thres[c*ADC_BITS +: ADC_BITS] < r_adc[c*ADC_BITS +: ADC_BITS]) &&
                          (r_adc[c*ADC_BITS +: ADC_BITS] <= r_up[c*ADC_BITS +: ADC_BITS]) && r_en[c];
        assign w_old    = r_win[w_tap];
        assign w_sb[c]  = (32'(r_occ) > 32'(OCCUPANCY)) && (r_intg3[c*INT_BITS +: INT_BITS] > INT_MIN);
        assign OCC[c*OW +: OW] = r_occ;
        always_ff @(posedge CLK120 or posedge RESET) begin
            if (RESET) begin
                r_win <= '0;
                r_occ <= '0;
            end else if (w_clr) begin
                r_win <= '0;
                r_occ <= '0;
            end else if (STROBE) begin
                r_win <= (r_win << 1) | MAX_WIDTH'(r_hit[c]);
                r_occ <= (r_hit[c] && !w_old) ? r_occ + OW'(1) :
                         (!r_hit[c] && w_old) ? r_occ - OW'(1) : r_occ;
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NCH; k++) w_cnt = w_cnt + MW'(SB_TRIG[k]);
    end

    assign w_cond = (w_cnt >= MULTIPLICITY) && (MULTIPLICITY != '0);

`ifdef TOTD_GEN_HOLDOFF_EN
    logic [15:0] r_hold;
    assign w_fire = w_cond && !r_trig_now && (r_hold == '0);
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET)       r_hold <= '0;
        else if (w_clr)  r_hold <= '0;
        else if (STROBE) r_hold <= w_fire ? HOLDOFF : (r_hold != '0) ? r_hold - 16'd1 : r_hold;
    end
`else
    logic w_unused_holdoff;
    assign w_unused_holdoff = ^HOLDOFF;
    assign w_fire = w_cond && !r_trig_now;
`endif

    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            r_adc      <= '0;
            r_thres    <= '0;
            r_up       <= '0;
            r_en       <= '0;
            r_intg1    <= '0;
            r_intg2    <= '0;
            r_intg3    <= '0;
            r_hit      <= '0;
            r_wl       <= '0;
            r_trig_now <= 1'b0;
            SB_TRIG    <= '0;
            TRIG       <= 1'b0;
        end else begin
            r_wl <= w_wl;
            if (STROBE) begin
                r_adc   <= ADC;
                r_thres <= THRES;
                r_up    <= UP;
                r_en    <= TRIG_ENABLE;
                r_intg1 <= INTG;
                r_intg2 <= r_intg1;
                r_intg3 <= r_intg2;
            end
            if (w_clr) begin
                r_hit      <= '0;
                SB_TRIG    <= '0;
                r_trig_now <= 1'b0;
                TRIG       <= 1'b0;
            end else if (STROBE) begin
                r_hit      <= w_hit;
                SB_TRIG    <= w_sb;
                r_trig_now <= w_cond;
                TRIG       <= w_fire;
            end else begin
                TRIG <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_totd_trigger_gen.sv
// tb_totd_trigger_gen: directed checks of the ToTd trigger with STROBE on every third clock.
module tb_totd_trigger_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0, clear = 1'b0;
    logic [35:0] adc = '0, thres = '0, up = '0;
    logic [56:0] intg = '0;
    logic [2:0]  trig_en = '0;
    logic [1:0]  mult = '0;
    logic [6:0]  win_len = 7'd120, occupancy = '0;
    logic [18:0] int_min = '0;
    logic [15:0] holdoff = '0;
    logic        trig;
    logic [2:0]  sb_trig;
    logic [20:0] occ;
    int checks = 0, errors = 0;
    int pulses = 0, wide = 0, scnt = 0, last = 0, gap = 0;

    always #5 clk = ~clk;

    totd_trigger_gen dut (
        .CLK120(clk), .RESET(rst), .STROBE(strobe), .CLEAR(clear),
        .ADC(adc), .INTG(intg), .THRES(thres), .UP(up), .TRIG_ENABLE(trig_en),
        .MULTIPLICITY(mult), .WIN_LEN(win_len), .OCCUPANCY(occupancy),
        .INT_MIN(int_min), .HOLDOFF(holdoff),
        .TRIG(trig), .SB_TRIG(sb_trig), .OCC(occ)
    );

    function automatic logic [35:0] v3(input int a, input int b, input int c);
        return {12'(c), 12'(b), 12'(a)};
    endfunction

    task automatic step(input logic [35:0] a, input logic clr);
        adc = a;
        clear = clr;
        strobe = 1'b1;
        @(negedge clk);
        scnt++;
        if (trig) begin
            pulses++;
            gap = scnt - last;
            last = scnt;
        end
        strobe = 1'b0;
        clear = 1'b0;
        adc = '0;
        repeat (2) begin
            @(negedge clk);
            if (trig) wide++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %b want 0", trig); end
        checks++; if (sb_trig !== 3'b000) begin errors++; $display("FAIL reset_sb got %b want 000", sb_trig); end
        checks++; if (occ !== '0) begin errors++; $display("FAIL reset_occ got %h want 0", occ); end
        rst = 1'b0;
        thres = {3{12'd100}};
        up = {3{12'd1000}};
        intg = {3{19'd5}};
        trig_en = 3'b111;
        mult = 2'd1;
        idle(3);
    endtask

    task automatic test_basic();
        int p0;
        p0 = pulses;
        step(v3(500, 0, 0), 1'b0);
        step('0, 1'b0);
        checks++; if (occ[6:0] !== 7'd0) begin errors++; $display("FAIL basic_occ_e1 got %0d want 0", occ[6:0]); end
        step('0, 1'b0);
        checks++; if (occ !== {7'd0, 7'd0, 7'd1}) begin errors++; $display("FAIL basic_occ_e2 got %h want 1 on ch0", occ); end
        step('0, 1'b0);
        checks++; if (sb_trig !== 3'b001 || pulses !== p0) begin errors++; $display("FAIL basic_e3 sb %b pulses %0d want 001 %0d", sb_trig, pulses, p0); end
        step('0, 1'b0);
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL basic_trig_e4 got %0d want %0d", pulses - p0, 1); end
        idle(117);
        checks++; if (occ[6:0] !== 7'd1) begin errors++; $display("FAIL basic_occ_e121 got %0d want 1", occ[6:0]); end
        step('0, 1'b0);
        checks++; if (occ[6:0] !== 7'd0) begin errors++; $display("FAIL basic_occ_e122 got %0d want 0", occ[6:0]); end
        checks++; if (pulses !== p0 + 1 || wide !== 0) begin errors++; $display("FAIL basic_single pulses %0d wide %0d want 1 0", pulses - p0, wide); end
    endtask

    task automatic test_thresholds();
        int p0;
        idle(2);
        pulse_clear();
        p0 = pulses;
        step(v3(100, 100, 100), 1'b0);
        idle(5);
        checks++; if (occ !== '0) begin errors++; $display("FAIL thr_at_low got %h want 0", occ); end
        step(v3(1001, 1001, 1001), 1'b0);
        idle(5);
        checks++; if (occ !== '0) begin errors++; $display("FAIL thr_above_up got %h want 0", occ); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL thr_no_trig got %0d want 0", pulses - p0); end
        step(v3(1000, 1000, 1000), 1'b0);
        idle(2);
        checks++; if (occ !== {7'd1, 7'd1, 7'd1}) begin errors++; $display("FAIL thr_at_up got %h want 1 each", occ); end
    endtask

    task automatic test_integral();
        int p0;
        idle(2);
        pulse_clear();
        occupancy = 7'd3;
        mult = 2'd2;
        intg = {3{19'd10}};
        int_min = 19'd10;
        p0 = pulses;
        repeat (4) step(v3(500, 500, 0), 1'b0);
        idle(6);
        checks++; if (occ[6:0] !== 7'd4) begin errors++; $display("FAIL int10_occ got %0d want 4", occ[6:0]); end
        checks++; if (sb_trig !== 3'b000) begin errors++; $display("FAIL int10_sb got %b want 000", sb_trig); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL int10_trig got %0d want 0", pulses - p0); end
        pulse_clear();
        intg = {3{19'd11}};
        p0 = pulses;
        repeat (4) step(v3(500, 500, 0), 1'b0);
        idle(18);
        checks++; if (occ[13:0] !== {7'd4, 7'd4}) begin errors++; $display("FAIL int11_occ got %h want 4,4", occ[13:0]); end
        checks++; if (sb_trig !== 3'b011) begin errors++; $display("FAIL int11_sb got %b want 011", sb_trig); end
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL int11_one_pulse got %0d want 1", pulses - p0); end
    endtask

    task automatic test_win_len();
        idle(2);
        pulse_clear();
        occupancy = 7'd0;
        mult = 2'd1;
        repeat (7) step(v3(500, 0, 0), 1'b0);
        idle(2);
        checks++; if (occ[6:0] !== 7'd7) begin errors++; $display("FAIL wl_occ7 got %0d want 7", occ[6:0]); end
        win_len = 7'd10;
        @(negedge clk);
        checks++; if (occ[6:0] !== 7'd0) begin errors++; $display("FAIL wl_change_clear got %0d want 0", occ[6:0]); end
        repeat (12) step(v3(500, 0, 0), 1'b0);
        idle(2);
        checks++; if (occ[6:0] !== 7'd10) begin errors++; $display("FAIL wl_saturate got %0d want 10", occ[6:0]); end
        win_len = 7'd0;
        @(negedge clk);
        repeat (3) step(v3(500, 0, 0), 1'b0);
        idle(2);
        checks++; if (occ[6:0] !== 7'd1) begin errors++; $display("FAIL wl_zero_as_one got %0d want 1", occ[6:0]); end
        step('0, 1'b0);
        checks++; if (occ[6:0] !== 7'd0) begin errors++; $display("FAIL wl_zero_drop got %0d want 0", occ[6:0]); end
        win_len = 7'd120;
        idle(2);
    endtask

    task automatic test_clear_strobe();
        step(v3(500, 0, 0), 1'b0);
        step('0, 1'b1);
        idle(4);
        checks++; if (occ[6:0] !== 7'd0) begin errors++; $display("FAIL clr_p2 got %0d want 0", occ[6:0]); end
        step(v3(500, 0, 0), 1'b0);
        step('0, 1'b0);
        step('0, 1'b1);
        idle(4);
        checks++; if (occ[6:0] !== 7'd0) begin errors++; $display("FAIL clr_p3 got %0d want 0", occ[6:0]); end
    endtask

    task automatic test_reset_mid_trig();
        step(v3(500, 0, 0), 1'b0);
        idle(3);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        checks++; if (trig !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", trig); end
        #2 rst = 1'b1;
        #1;
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL rst_mid_trig got %b want 0", trig); end
        checks++; if (occ !== '0 || sb_trig !== 3'b000) begin errors++; $display("FAIL rst_mid_state occ %h sb %b want 0 000", occ, sb_trig); end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_mult_zero();
        int p0;
        mult = 2'd0;
        intg = {3{19'd5}};
        int_min = 19'd0;
        p0 = pulses;
        step(v3(500, 500, 500), 1'b0);
        idle(6);
        checks++; if (sb_trig !== 3'b111) begin errors++; $display("FAIL m0_sb got %b want 111", sb_trig); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL m0_trig got %0d want 0", pulses - p0); end
    endtask

`ifdef TOTD_GEN_HOLDOFF_EN
    task automatic test_holdoff();
        int p0;
        mult = 2'd1;
        win_len = 7'd1;
        holdoff = 16'd5;
        idle(2);
        pulse_clear();
        p0 = pulses;
        repeat (4) begin
            step(v3(500, 0, 0), 1'b0);
            step(v3(500, 0, 0), 1'b0);
            idle(2);
        end
        idle(6);
        checks++; if (pulses !== p0 + 2) begin errors++; $display("FAIL hold_pulses got %0d want 2", pulses - p0); end
        checks++; if (gap !== 8) begin errors++; $display("FAIL hold_gap got %0d want 8", gap); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_thresholds();
        test_integral();
        test_win_len();
        test_clear_strobe();
        test_reset_mid_trig();
        test_mult_zero();
`ifdef TOTD_GEN_HOLDOFF_EN
        test_holdoff();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
